// File: rtl/tone_synth_if.sv
// CODEC write-side bus: sample strobe, stereo 24-bit data and FIFO-ready backpressure.
interface tone_synth_if;
  logic        write;
  logic        write_ready;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;

  modport master (output write, output writedata_left, output writedata_right, input write_ready);
  modport slave  (input write, input writedata_left, input writedata_right, output write_ready);
endinterface

// File: rtl/tone_synth.sv
// Square-wave tone burst generator feeding the audio CODEC write port.
// Optional rising-transition counter enabled by macro TONE_SYNTH_ZC_COUNT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | burst parameters captured, busy raised
// RUN    | one sample per write_ready cycle
// DONE   | one-cycle done pulse
module tone_synth #(
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter logic [23:0] AMP         = 24'h200000,
  parameter int unsigned MAX_FREQ    = 23999
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [15:0]  freq_hz,
  input  logic [15:0]  duration,
  tone_synth_if.master codec,
  output logic         busy,
  output logic         done
`ifdef TONE_SYNTH_ZC_COUNT_EN
  ,
  output logic [15:0]  zc_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [16:0] RATE = 17'(SAMPLE_RATE);
  localparam logic [15:0] HALF = 16'(SAMPLE_RATE / 2);
  localparam logic [15:0] FMAX = 16'(MAX_FREQ);
  localparam logic [23:0] AMP_NEG = ~AMP + 24'd1;

  logic [1:0]  state;
  logic [15:0] phase;
  logic [15:0] remaining;
  logic [15:0] freq_q;
  logic        xfer;
  logic        positive;
  logic [16:0] phase_sum;
  logic [15:0] phase_next;
  logic [23:0] sample;

  assign xfer      = (state == S_RUN) && codec.write_ready;
  assign positive  = (phase < HALF);
  assign phase_sum = {1'b0, phase} + {1'b0, freq_q};
  assign phase_next = (phase_sum >= RATE) ? 16'(phase_sum - RATE) : phase_sum[15:0];

  // Data is zero outside RUN so a reset or idle bus never shows a stale sample.
  always_comb begin
    sample = 24'd0;
    if (state == S_RUN && freq_q != 16'd0)
      sample = positive ? AMP : AMP_NEG;
  end

  assign codec.write           = xfer;
  assign codec.writedata_left  = sample;
  assign codec.writedata_right = sample;
  assign busy = (state == S_LOAD) || (state == S_RUN);
  assign done = (state == S_DONE);

  // Burst parameters are captured on the start edge so LOAD sees them already registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase     <= 16'd0;
      remaining <= 16'd0;
      freq_q    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            freq_q    <= (freq_hz > FMAX) ? FMAX : freq_hz;
            remaining <= duration;
            phase     <= 16'd0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= (abort || remaining == 16'd0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (xfer) begin
            phase     <= phase_next;
            remaining <= remaining - 16'd1;
          end
          if (abort || (xfer && remaining == 16'd1))
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TONE_SYNTH_ZC_COUNT_EN
  logic prev_neg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zc_count <= 16'd0;
      prev_neg <= 1'b1;
    end else if (state == S_LOAD) begin
      zc_count <= 16'd0;
      prev_neg <= 1'b1;
    end else if (xfer && freq_q != 16'd0) begin
      if (positive && prev_neg && zc_count != 16'hFFFF)
        zc_count <= zc_count + 16'd1;
      prev_neg <= !positive;
    end
  end
`endif

endmodule

// File: tb/tb_tone_synth.sv
// Directed self-checking bench for tone_synth; define TONE_SYNTH_ZC_COUNT_EN to also check zc_count.
module tb_tone_synth;
  localparam logic [23:0] AMP_P = 24'h200000;
  localparam logic [23:0] AMP_N = 24'hE00000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] freq_hz;
  logic [15:0] duration;
  logic        busy;
  logic        done;
`ifdef TONE_SYNTH_ZC_COUNT_EN
  logic [15:0] zc_count;
`endif

  tone_synth_if codec_bus ();

  tone_synth dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .freq_hz  (freq_hz),
    .duration (duration),
    .codec    (codec_bus),
    .busy     (busy),
    .done     (done)
`ifdef TONE_SYNTH_ZC_COUNT_EN
    ,
    .zc_count (zc_count)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int lr_bad = 0;
  logic [23:0] samples[$];
  logic [23:0] nominal[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (codec_bus.write) begin
      wr_cnt++;
      samples.push_back(codec_bus.writedata_left);
      if (codec_bus.writedata_right !== codec_bus.writedata_left) lr_bad++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    wr_cnt = 0;
    done_cnt = 0;
    samples.delete();
  endtask

  task automatic start_burst(input logic [15:0] f, input logic [15:0] d);
    freq_hz  = f;
    duration = d;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Waits for done; optional 1,0,0,1 ready stall pattern and a stray start at cycle restart_at.
  task automatic wait_done(input string tag, input int budget, input bit stall, input int restart_at);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      if (stall) codec_bus.write_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      start = (cyc == restart_at);
      step();
      cyc++;
      seen = done;
    end
    start = 1'b0;
    codec_bus.write_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    step();
    step();
  endtask

  function automatic int seq_errs(input int fq, input int n);
    int ph;
    int e;
    logic [23:0] x;
    ph = 0;
    e = (samples.size() != n) ? 1 : 0;
    for (int i = 0; i < n && i < samples.size(); i++) begin
      x = (fq == 0) ? 24'd0 : ((ph < 24000) ? AMP_P : AMP_N);
      if (samples[i] !== x) e++;
      ph = ph + fq;
      if (ph >= 48000) ph = ph - 48000;
    end
    return e;
  endfunction

  function automatic int rising_count();
    int c;
    bit prev_neg;
    c = 0;
    prev_neg = 1'b1;
    foreach (samples[i]) begin
      if (samples[i] === AMP_P) begin
        if (prev_neg) c++;
        prev_neg = 1'b0;
      end else if (samples[i] === AMP_N) begin
        prev_neg = 1'b1;
      end
    end
    return c;
  endfunction

  initial begin
    int saved_wr;
    int errs;
    bit hit;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    freq_hz = 16'd0;
    duration = 16'd0;
    codec_bus.write_ready = 1'b1;
    step();
    step();
    chk("rst_write", 32'(codec_bus.write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(codec_bus.writedata_left), 32'd0);
    reset = 1'b1;
    step();

    // Asynchronous reset in the middle of a burst
    clear_counts();
    start_burst(16'd440, 16'd100);
    repeat (10) step();
    chk("mid_write_before", 32'(codec_bus.write), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_write", 32'(codec_bus.write), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", 32'(codec_bus.writedata_left), 32'd0);
    step();
    reset = 1'b1;
    saved_wr = wr_cnt;
    repeat (5) step();
    chk("arst_no_writes", 32'(wr_cnt), 32'(saved_wr));
    chk("arst_idle_busy", 32'(busy), 32'd0);

    // One second of 440 Hz
    clear_counts();
    start_burst(16'd440, 16'd48000);
    wait_done("f440", 48100, 1'b0, -1);
    chk("f440_writes", 32'(wr_cnt), 32'd48000);
    chk("f440_first", 32'(samples[0]), 32'(AMP_P));
    chk("f440_seq", 32'(seq_errs(440, 48000)), 32'd0);
    chk("f440_rising", 32'(rising_count()), 32'd440);
    chk("f440_done_once", 32'(done_cnt), 32'd1);
    chk("f440_lr", 32'(lr_bad), 32'd0);
`ifdef TONE_SYNTH_ZC_COUNT_EN
    chk("f440_zc", 32'(zc_count), 32'd440);
`endif

    // Requested frequency above the clamp
    clear_counts();
    start_burst(16'd30000, 16'd8);
    wait_done("clamp", 40, 1'b0, -1);
    chk("clamp_writes", 32'(wr_cnt), 32'd8);
    chk("clamp_s1", 32'(samples[1]), 32'(AMP_P));
    chk("clamp_s2", 32'(samples[2]), 32'(AMP_N));
    chk("clamp_seq", 32'(seq_errs(23999, 8)), 32'd0);
`ifdef TONE_SYNTH_ZC_COUNT_EN
    chk("clamp_zc", 32'(zc_count), 32'd4);
`endif

    // Stall run compared against the free-running run
    clear_counts();
    start_burst(16'd1000, 16'd100);
    wait_done("nostall", 200, 1'b0, -1);
    chk("nostall_seq", 32'(seq_errs(1000, 100)), 32'd0);
    nominal = samples;
    clear_counts();
    start_burst(16'd1000, 16'd100);
    wait_done("stall", 400, 1'b1, -1);
    chk("stall_writes", 32'(wr_cnt), 32'd100);
    errs = (samples.size() != nominal.size()) ? 1 : 0;
    foreach (samples[i]) if (i < nominal.size() && samples[i] !== nominal[i]) errs++;
    chk("stall_same_seq", 32'(errs), 32'd0);

    // Zero-length burst
    clear_counts();
    start_burst(16'd1000, 16'd0);
    chk("zero_busy_load", 32'(busy), 32'd1);
    wait_done("zero", 10, 1'b0, -1);
    chk("zero_writes", 32'(wr_cnt), 32'd0);
    chk("zero_done_once", 32'(done_cnt), 32'd1);

    // Start while busy is ignored
    clear_counts();
    start_burst(16'd1000, 16'd10);
    wait_done("restart", 40, 1'b0, 3);
    repeat (5) step();
    chk("restart_writes", 32'(wr_cnt), 32'd10);
    chk("restart_done_once", 32'(done_cnt), 32'd1);
    chk("restart_idle", 32'(busy), 32'd0);

    // Abort together with the 5th transfer
    clear_counts();
    start_burst(16'd1000, 16'd20);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (codec_bus.write && wr_cnt == 4) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        hit = 1'b1;
        chk("abort_done_next", 32'(done), 32'd1);
      end else begin
        step();
      end
    end
    chk("abort_reached", 32'(hit), 32'd1);
    repeat (4) step();
    chk("abort_writes", 32'(wr_cnt), 32'd5);
    chk("abort_done_once", 32'(done_cnt), 32'd1);

    // Silent burst
    clear_counts();
    start_burst(16'd0, 16'd4);
    wait_done("silent", 20, 1'b0, -1);
    chk("silent_writes", 32'(wr_cnt), 32'd4);
    chk("silent_seq", 32'(seq_errs(0, 4)), 32'd0);
`ifdef TONE_SYNTH_ZC_COUNT_EN
    chk("silent_zc", 32'(zc_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
